wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file of the five-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs, selects write data and destination register, and commits the result into a 32×32 register file. Serves the ID stage's two combinational read ports with write-first bypass, and exports the committed write for EX-stage forwarding. Keeps a counter of committed register writes for debug.

## Interface
Parameters:
- `RESET_PC`, 32'h80000000: reference value; a `wb_pc` equal to it after reset is a bubble and carries no special handling.

Ports. Clock clk; reset reset, asynchronous, active-high.
- `clk`  in  1  clock
- `reset`  in  1  asynchronous active-high reset
- `wb_in_a`  in  32  ALU result from MEM/WB
- `wb_in_b`  in  32  memory load data from MEM/WB
- `wb_pc`  in  32  PC of the instruction in WB
- `wb_memtoreg`  in  2  data select: 00 ALU, 01 load, 10 `wb_pc`+4 (link), 11 `wb_pc` (exception save)
- `wb_regdst`  in  2  destination select: 00 `wb_wrreg` (rt), 01 `wb_rd`, 10 $31 ($ra), 11 $26 ($k0)
- `wb_regwr`  in  1  write enable
- `wb_wrreg`  in  5  rt field
- `wb_rd`  in  5  rd field
- `id_rs_addr`, `id_rt_addr`  in  5 each  ID read addresses
- `id_rs_data`, `id_rt_data`  out  32 each  ID read data (combinational)
- `wb_fwd_en`  out  1  effective write this cycle
- `wb_fwd_addr`  out  5  effective destination
- `wb_fwd_data`  out  32  selected write data
- `wr_count`  out  32  committed-write counter

## Operation
- Destination mux: `dest` per `wb_regdst` encoding above.
- Data mux: `wdata` per `wb_memtoreg`; link value `wb_pc + 32'd4`, modulo 2^32 (32'hFFFFFFFC → 32'h00000000).
- Effective write `we_eff = wb_regwr && dest != 0`. Writes to $0 are discarded; $0 always reads 0.
- On posedge clk with `we_eff`: `regs[dest] <= wdata`; `wr_count <= wr_count + 1` (wraps 32'hFFFFFFFF → 0). No count for suppressed $0 writes or `wb_regwr=0`.
- Read ports: addr 0 → 0; else if `we_eff && addr == dest` → `wdata` (write-first bypass); else `regs[addr]`. Both ports independent; both may bypass the same write.
- Forward outputs: `wb_fwd_en = we_eff`, `wb_fwd_addr = dest`, `wb_fwd_data = wdata`, purely combinational; `wb_fwd_addr`/`wb_fwd_data` valid regardless of enable.
- Reset: all 31 writable registers and `wr_count` cleared to 0 asynchronously; combinational outputs follow inputs immediately (register contents read 0).

## Timing
- Register update and counter increment on posedge clk only; read data and forward outputs zero-latency combinational.
- Write in cycle N visible from `regs` at cycle N+1; visible via bypass within cycle N.
- Reset asserted mid-write: reset wins, register stays 0, counter stays 0. First write accepted at first posedge after reset deassertion.
- No stall/flush inputs: bubbles arrive as `wb_regwr=0` from MEM/WB.

## Test plan
- Reset, then read all 32 addresses on both ports → all 0; `wr_count`=0; `wb_fwd_en`=0.
- `wb_regwr`=1, regdst=01, rd=5, memtoreg=00, in_a=32'h12345678, `id_rs_addr`=5 → `id_rs_data`=32'h12345678 same cycle (bypass) and after edge from storage; `wr_count`=1.
- regdst=10, memtoreg=10, wb_pc=32'h80000010 → $31 = 32'h80000014; wb_pc=32'hFFFFFFFC → $31 = 0 (wrap); regdst=11, memtoreg=11, wb_pc=32'h80000040 → $26 = 32'h80000040.
- Write to $0 (regdst=00, wrreg=0, in_b=32'hDEADBEEF, memtoreg=01) → $0 reads 0, `wb_fwd_en`=0, `wr_count` unchanged.
- Both ports read addr 9 while writing 9 with load data 32'hCAFEF00D → both outputs 32'hCAFEF00D; `wb_regwr`=0 same setup → both show old $9.
- Preload `wr_count` to 32'hFFFFFFFF via writes (or force), one more write → 0; assert reset between edges mid-sequence → all registers and counter 0 immediately.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Bundle of MEM/WB inputs, ID read ports and WB forwarding outputs of the write-back stage.
// Latency: wiring only.
// Backpressure: none; the pipeline advances every cycle and bubbles arrive as wb_regwr=0.
interface wb_regfile_if;
    logic [31:0] wb_in_a;
    logic [31:0] wb_in_b;
    logic [31:0] wb_pc;
    logic [1:0]  wb_memtoreg;
    logic [1:0]  wb_regdst;
    logic        wb_regwr;
    logic [4:0]  wb_wrreg;
    logic [4:0]  wb_rd;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        wb_fwd_en;
    logic [4:0]  wb_fwd_addr;
    logic [31:0] wb_fwd_data;
    logic [31:0] wr_count;

    // Register file side: consumes MEM/WB and read addresses, drives data back.
    modport slave (
        input  wb_in_a, wb_in_b, wb_pc, wb_memtoreg, wb_regdst, wb_regwr,
               wb_wrreg, wb_rd, id_rs_addr, id_rt_addr,
        output id_rs_data, id_rt_data, wb_fwd_en, wb_fwd_addr, wb_fwd_data, wr_count
    );

    // Pipeline side: drives MEM/WB and read addresses, observes results.
    modport master (
        output wb_in_a, wb_in_b, wb_pc, wb_memtoreg, wb_regdst, wb_regwr,
               wb_wrreg, wb_rd, id_rs_addr, id_rt_addr,
        input  id_rs_data, id_rt_data, wb_fwd_en, wb_fwd_addr, wb_fwd_data, wr_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: selects write data/destination and commits into the 32x32 register file.
// Latency: reads and forwarding are combinational (write-first bypass); storage updates at posedge.
// Backpressure: none; every MEM/WB beat is consumed in its cycle.
module wb_regfile #(
    parameter logic [31:0] RESET_PC = 32'h80000000
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);

    // A bubble's wb_pc equals RESET_PC and needs no special handling, but the
    // value must be a word address for the link arithmetic to make sense.
    if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_align
        $error("wb_regfile: RESET_PC must be word aligned");
    end

    logic [31:0] regs_q [32];
    logic [31:0] wr_count_q;
    logic [31:0] wr_count_d;
    logic [4:0]  dest;
    logic [31:0] wdata;
    logic        we_eff;

    // Destination and write-data selection for the instruction in WB.
    always_comb begin
        dest  = bus.wb_wrreg;
        wdata = bus.wb_in_a;
        unique case (bus.wb_regdst)
            2'b00:   dest = bus.wb_wrreg;
            2'b01:   dest = bus.wb_rd;
            2'b10:   dest = 5'd31;
            default: dest = 5'd26;
        endcase
        unique case (bus.wb_memtoreg)
            2'b00:   wdata = bus.wb_in_a;
            2'b01:   wdata = bus.wb_in_b;
            2'b10:   wdata = bus.wb_pc + 32'd4;
            default: wdata = bus.wb_pc;
        endcase
        // $0 is hardwired; a write aimed at it is dropped and not counted.
        we_eff     = bus.wb_regwr && (dest != 5'd0);
        wr_count_d = we_eff ? wr_count_q + 32'd1 : wr_count_q;
    end

    // Read ports with write-first bypass so ID sees this cycle's commit.
    always_comb begin
        bus.id_rs_data = regs_q[bus.id_rs_addr];
        bus.id_rt_data = regs_q[bus.id_rt_addr];
        if (bus.id_rs_addr == 5'd0) begin
            bus.id_rs_data = '0;
        end else if (we_eff && (bus.id_rs_addr == dest)) begin
            bus.id_rs_data = wdata;
        end
        if (bus.id_rt_addr == 5'd0) begin
            bus.id_rt_data = '0;
        end else if (we_eff && (bus.id_rt_addr == dest)) begin
            bus.id_rt_data = wdata;
        end
    end

    // Forwarding to EX; address/data are meaningful even when the enable is low.
    always_comb begin
        bus.wb_fwd_en   = we_eff;
        bus.wb_fwd_addr = dest;
        bus.wb_fwd_data = wdata;
        bus.wr_count    = wr_count_q;
    end

    // Register storage; entry 0 is only ever cleared, so it stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_eff) begin
            regs_q[dest] <= wdata;
        end
    end

    // Committed-write counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: expectations queued when stimulus is applied, popped at sampling.
// Latency: samples 1 ns after input changes or after the posedge, never on the edge.
// Backpressure: not applicable; the DUT accepts every cycle.
module tb_wb_regfile;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];

    wb_regfile_if bus ();

    wb_regfile #(.RESET_PC(32'h80000000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue an expected value for the next sampled observation.
    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with an observed DUT value.
    task automatic check_obs(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic set_wb(input logic regwr, input logic [1:0] regdst, input logic [1:0] m2r,
                          input logic [4:0] wrreg, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        bus.wb_regwr    = regwr;
        bus.wb_regdst   = regdst;
        bus.wb_memtoreg = m2r;
        bus.wb_wrreg    = wrreg;
        bus.wb_rd       = rd;
        bus.wb_in_a     = a;
        bus.wb_in_b     = b;
        bus.wb_pc       = pc;
    endtask

    task automatic set_rd(input logic [4:0] rs, input logic [4:0] rt);
        bus.id_rs_addr = rs;
        bus.id_rt_addr = rt;
    endtask

    // Commit the currently driven write and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Absolute bound on the run.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        set_wb(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, '0, '0, 32'h80000000);
        set_rd(5'd0, 5'd0);

        // Under reset every address reads zero on both ports.
        #2;
        for (int a = 0; a < 32; a++) begin
            set_rd(a[4:0], 5'(31 - a));
            #1;
            expect_val($sformatf("reset_rs%0d", a), 32'h0);
            expect_val($sformatf("reset_rt%0d", 31 - a), 32'h0);
            check_obs(bus.id_rs_data);
            check_obs(bus.id_rt_data);
        end
        expect_val("reset_count", 32'h0);
        expect_val("reset_fwd_en", 32'h0);
        check_obs(bus.wr_count);
        check_obs({31'b0, bus.wb_fwd_en});

        @(negedge clk);
        reset = 1'b0;

        // ALU write to rd=5: bypass in-cycle, storage after the edge.
        set_wb(1'b1, 2'b01, 2'b00, 5'd0, 5'd5, 32'h12345678, '0, 32'h80000000);
        set_rd(5'd5, 5'd0);
        #1;
        expect_val("rd5_bypass", 32'h12345678);
        expect_val("rd5_fwd_en", 32'h1);
        expect_val("rd5_fwd_addr", 32'd5);
        expect_val("rd5_fwd_data", 32'h12345678);
        check_obs(bus.id_rs_data);
        check_obs({31'b0, bus.wb_fwd_en});
        check_obs({27'b0, bus.wb_fwd_addr});
        check_obs(bus.wb_fwd_data);
        tick();
        bus.wb_regwr = 1'b0;
        #1;
        expect_val("rd5_stored", 32'h12345678);
        expect_val("count_1", 32'd1);
        check_obs(bus.id_rs_data);
        check_obs(bus.wr_count);

        // Link write to $31.
        @(negedge clk);
        set_wb(1'b1, 2'b10, 2'b10, 5'd0, 5'd0, '0, '0, 32'h80000010);
        set_rd(5'd31, 5'd0);
        #1;
        expect_val("link_bypass", 32'h80000014);
        check_obs(bus.id_rs_data);
        tick();
        bus.wb_regwr = 1'b0;
        #1;
        expect_val("link_stored", 32'h80000014);
        expect_val("count_2", 32'd2);
        check_obs(bus.id_rs_data);
        check_obs(bus.wr_count);

        // Link arithmetic wraps past the top of the address space.
        @(negedge clk);
        set_wb(1'b1, 2'b10, 2'b10, 5'd0, 5'd0, '0, '0, 32'hFFFFFFFC);
        #1;
        expect_val("link_wrap_fwd", 32'h0);
        check_obs(bus.wb_fwd_data);
        tick();
        bus.wb_regwr = 1'b0;
        #1;
        expect_val("link_wrap_stored", 32'h0);
        expect_val("count_3", 32'd3);
        check_obs(bus.id_rs_data);
        check_obs(bus.wr_count);

        // Exception save of wb_pc into $26 ($k0).
        @(negedge clk);
        set_wb(1'b1, 2'b11, 2'b11, 5'd0, 5'd0, '0, '0, 32'h80000040);
        set_rd(5'd0, 5'd26);
        #1;
        expect_val("k0_fwd_addr", 32'd26);
        check_obs({27'b0, bus.wb_fwd_addr});
        tick();
        bus.wb_regwr = 1'b0;
        #1;
        expect_val("k0_stored", 32'h80000040);
        expect_val("count_4", 32'd4);
        check_obs(bus.id_rt_data);
        check_obs(bus.wr_count);

        // Load aimed at $0 is suppressed entirely.
        @(negedge clk);
        set_wb(1'b1, 2'b00, 2'b01, 5'd0, 5'd0, '0, 32'hDEADBEEF, 32'h80000000);
        set_rd(5'd0, 5'd0);
        #1;
        expect_val("r0_read", 32'h0);
        expect_val("r0_fwd_en", 32'h0);
        expect_val("r0_fwd_data", 32'hDEADBEEF);
        check_obs(bus.id_rs_data);
        check_obs({31'b0, bus.wb_fwd_en});
        check_obs(bus.wb_fwd_data);
        tick();
        bus.wb_regwr = 1'b0;
        #1;
        expect_val("r0_after", 32'h0);
        expect_val("r0_count", 32'd4);
        check_obs(bus.id_rt_data);
        check_obs(bus.wr_count);

        // Seed $9 with an old value.
        @(negedge clk);
        set_wb(1'b1, 2'b01, 2'b00, 5'd0, 5'd9, 32'h11111111, '0, 32'h80000000);
        tick();
        bus.wb_regwr = 1'b0;

        // Both ports bypass the same load into $9; without regwr they see the old value.
        @(negedge clk);
        set_wb(1'b1, 2'b00, 2'b01, 5'd9, 5'd0, '0, 32'hCAFEF00D, 32'h80000000);
        set_rd(5'd9, 5'd9);
        #1;
        expect_val("dual_bypass_rs", 32'hCAFEF00D);
        expect_val("dual_bypass_rt", 32'hCAFEF00D);
        check_obs(bus.id_rs_data);
        check_obs(bus.id_rt_data);
        bus.wb_regwr = 1'b0;
        #1;
        expect_val("dual_old_rs", 32'h11111111);
        expect_val("dual_old_rt", 32'h11111111);
        expect_val("count_5", 32'd5);
        check_obs(bus.id_rs_data);
        check_obs(bus.id_rt_data);
        check_obs(bus.wr_count);
        bus.wb_regwr = 1'b1;
        tick();
        bus.wb_regwr = 1'b0;
        #1;
        expect_val("dual_stored_rs", 32'hCAFEF00D);
        expect_val("count_6", 32'd6);
        check_obs(bus.id_rt_data);
        check_obs(bus.wr_count);

        // Counter wrap: preload to all-ones, one more write rolls to zero.
        @(negedge clk);
        force dut.wr_count_q = 32'hFFFFFFFF;
        #1;
        release dut.wr_count_q;
        #1;
        expect_val("count_preload", 32'hFFFFFFFF);
        check_obs(bus.wr_count);
        set_wb(1'b1, 2'b01, 2'b00, 5'd0, 5'd3, 32'hA5A5A5A5, '0, 32'h80000000);
        set_rd(5'd3, 5'd5);
        tick();
        bus.wb_regwr = 1'b0;
        #1;
        expect_val("count_wrap", 32'h0);
        expect_val("r3_stored", 32'hA5A5A5A5);
        check_obs(bus.wr_count);
        check_obs(bus.id_rs_data);

        // Reset between edges while a write is pending: everything clears at once.
        @(negedge clk);
        set_wb(1'b1, 2'b01, 2'b00, 5'd0, 5'd7, 32'h77777777, '0, 32'h80000000);
        set_rd(5'd5, 5'd3);
        #1;
        reset = 1'b1;
        #1;
        expect_val("mid_reset_r5", 32'h0);
        expect_val("mid_reset_r3", 32'h0);
        expect_val("mid_reset_count", 32'h0);
        check_obs(bus.id_rs_data);
        check_obs(bus.id_rt_data);
        check_obs(bus.wr_count);
        tick();
        bus.wb_regwr = 1'b0;
        set_rd(5'd7, 5'd9);
        #1;
        expect_val("reset_wins_r7", 32'h0);
        expect_val("reset_wins_r9", 32'h0);
        expect_val("reset_wins_count", 32'h0);
        check_obs(bus.id_rs_data);
        check_obs(bus.id_rt_data);
        check_obs(bus.wr_count);

        // First write after deassertion lands on the next edge.
        @(negedge clk);
        reset = 1'b0;
        bus.wb_regwr = 1'b1;
        tick();
        bus.wb_regwr = 1'b0;
        #1;
        expect_val("post_reset_r7", 32'h77777777);
        expect_val("post_reset_count", 32'd1);
        check_obs(bus.id_rs_data);
        check_obs(bus.wr_count);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
